// File: rtl/spinet_spi_port.sv
// SPI slave endpoint for a spinet ring node: a host injects WIDTH-bit packets over SPI
// and reads back the packets the ring delivered, one buffered packet in each direction.
module spinet_spi_port #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_sck,
  input  logic             spi_ss,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             txrdy,
  output logic             rxrdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_WAIT_SS_HIGH
  } state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_ss_d;

  logic                   w_sck;
  logic                   w_ss;
  logic                   w_mosi;
  logic                   w_sck_rise;
  logic                   w_sck_fall;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_rx;
  logic [WIDTH-1:0]       r_tx;
  logic                   r_loaded;
  logic                   r_miso;
  logic [WIDTH-1:0]       r_out_data;
  logic                   r_out_valid;
  logic [WIDTH-1:0]       r_in_buf;
  logic                   r_in_full;
  logic                   r_overflow;

  // Synchronizers run through reset so the FSM can see the live ss level while reset is held.
  always_ff @(posedge clk) begin
    r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
    r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss};
    r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
    r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_ss       = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= w_ss ? S_IDLE : S_WAIT_SS_HIGH;
      r_cnt       <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_loaded    <= 1'b0;
      r_miso      <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_buf    <= '0;
      r_in_full   <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_overflow <= 1'b0;

      // Ring-side handshakes; a host write later in this block overrides the drain.
      if (r_out_valid && out_ready)
        r_out_valid <= 1'b0;
      if (in_valid && !r_in_full) begin
        r_in_buf  <= in_data;
        r_in_full <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_miso <= 1'b0;
          if (!w_ss) begin
            r_state <= S_ACTIVE;
            r_cnt   <= '0;
            if (r_in_full) begin
              r_tx     <= r_in_buf;
              r_loaded <= 1'b1;
              r_miso   <= r_in_buf[WIDTH-1];
            end else begin
              r_tx     <= '0;
              r_loaded <= 1'b0;
            end
          end
        end

        S_ACTIVE: begin
          if (w_ss) begin
            r_state <= S_IDLE;
            r_miso  <= 1'b0;
            // Only an exact-length transaction commits; anything else is an abort.
            if (r_cnt == CNT_FULL) begin
              if (r_loaded)
                r_in_full <= 1'b0;
              if (r_rx[WIDTH-1]) begin
                if (!r_out_valid || out_ready) begin
                  r_out_data  <= r_rx;
                  r_out_valid <= 1'b1;
                end else begin
                  r_overflow <= 1'b1;
                end
              end
            end
          end else begin
            if (w_sck_rise) begin
              r_rx <= {r_rx[WIDTH-2:0], w_mosi};
              if (r_cnt != CNT_SAT)
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_sck_fall) begin
              r_tx   <= {r_tx[WIDTH-2:0], 1'b0};
              r_miso <= r_tx[WIDTH-2];
            end
          end
        end

        S_WAIT_SS_HIGH: begin
          r_miso <= 1'b0;
          if (w_ss)
            r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_miso  <= 1'b0;
        end
      endcase
    end
  end

  assign spi_miso  = r_miso;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;
  assign txrdy     = ~r_out_valid;
  assign rxrdy     = r_in_full;
  assign in_ready  = ~r_in_full;

endmodule

// File: tb/tb_spinet_spi_port.sv
// Scoreboard bench for spinet_spi_port: directed SPI host transactions and ring traffic,
// with expected packets/reads queued by the stimulus and checked by a separate monitor.
module tb_spinet_spi_port;

  localparam int W    = 16;
  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         spi_sck = 1'b0;
  logic         spi_ss = 1'b1;
  logic         spi_mosi = 1'b0;
  logic         spi_miso;
  logic         txrdy;
  logic         rxrdy;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         overflow;

  spinet_spi_port #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .txrdy(txrdy), .rxrdy(rxrdy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_out_q[$];
  logic [W-1:0] exp_rd_q[$];
  logic [W-1:0] act_rd_q[$];
  int exp_ovf  = 0;
  int ovf_seen = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic spi_bits(input logic [W-1:0] tx, input int n, output logic [W-1:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[W-1-i];
      tick(HALF);
      spi_sck = 1'b1;
      tick(HALF);
      rx = {rx[W-2:0], spi_miso};
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_xfer(input logic [W-1:0] tx, input int n, input bit record);
    logic [W-1:0] rx;
    spi_ss = 1'b0;
    tick(HALF);
    spi_bits(tx, n, rx);
    tick(HALF);
    spi_ss = 1'b1;
    tick(2 * HALF);
    if (record) act_rd_q.push_back(rx);
  endtask

  task automatic ring_deliver(input logic [W-1:0] pkt);
    in_data  = pkt;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  // Monitor: compares each newly presented outbound packet and each host read.
  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic [W-1:0] mon_rd;
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && (!pv || pr)) begin
        if (exp_out_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_pkt: got %h expected none", out_data);
        end else begin
          chk16("out_pkt", out_data, exp_out_q.pop_front());
        end
      end
      if (overflow) ovf_seen++;
      if (act_rd_q.size() > 0) begin
        mon_rd = act_rd_q.pop_front();
        if (exp_rd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL host_read: got %h expected none", mon_rd);
        end else begin
          chk16("host_read", mon_rd, exp_rd_q.pop_front());
        end
      end
    end
    pv = out_valid;
    pr = out_ready;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] junk;
    tick(6);
    reset = 1'b0;
    tick(1);
    chk1("rst_miso", spi_miso, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk16("rst_out_data", out_data, 16'h0000);
    chk1("rst_overflow", overflow, 1'b0);
    chk1("rst_txrdy", txrdy, 1'b1);
    chk1("rst_rxrdy", rxrdy, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);

    // Host write, then ring drains it
    exp_out_q.push_back(16'h8840);
    spi_xfer(16'h8840, 16, 1'b0);
    chk1("wr_out_valid", out_valid, 1'b1);
    chk16("wr_out_data", out_data, 16'h8840);
    chk1("wr_txrdy", txrdy, 1'b0);
    drain();
    chk1("drain_out_valid", out_valid, 1'b0);
    chk1("drain_txrdy", txrdy, 1'b1);

    // Host read of a ring-delivered packet
    ring_deliver(16'h8148);
    chk1("deliver_rxrdy", rxrdy, 1'b1);
    chk1("deliver_in_ready", in_ready, 1'b0);
    exp_rd_q.push_back(16'h8148);
    spi_xfer(16'h0000, 16, 1'b1);
    chk1("read_rxrdy", rxrdy, 1'b0);
    chk1("read_in_ready", in_ready, 1'b1);
    chk1("read_no_out", out_valid, 1'b0);

    // Empty read
    exp_rd_q.push_back(16'h0000);
    spi_xfer(16'h0000, 16, 1'b1);
    chk1("empty_rxrdy", rxrdy, 1'b0);
    chk1("empty_txrdy", txrdy, 1'b1);
    chk1("empty_no_out", out_valid, 1'b0);

    // Overflow while the outbound buffer is held
    exp_out_q.push_back(16'h8840);
    spi_xfer(16'h8840, 16, 1'b0);
    exp_ovf++;
    spi_xfer(16'h9040, 16, 1'b0);
    chk1("ovf_out_valid", out_valid, 1'b1);
    chk16("ovf_out_data", out_data, 16'h8840);
    drain();
    chk1("ovf_drain_txrdy", txrdy, 1'b1);

    // Abort after 10 bits leaves the inbound packet pending
    ring_deliver(16'hA255);
    spi_xfer(16'h8840, 10, 1'b0);
    chk1("abort_no_out", out_valid, 1'b0);
    chk1("abort_rxrdy", rxrdy, 1'b1);
    chk1("abort_in_ready", in_ready, 1'b0);
    exp_rd_q.push_back(16'hA255);
    spi_xfer(16'h0000, 16, 1'b1);
    chk1("after_abort_rxrdy", rxrdy, 1'b0);

    // Reset in the middle of a transaction
    spi_ss = 1'b0;
    tick(HALF);
    spi_bits(16'h8840, 8, junk);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk1("midrst_miso", spi_miso, 1'b0);
    chk1("midrst_out_valid", out_valid, 1'b0);
    spi_bits(16'hC0FF, 8, junk);
    chk1("wait_miso", spi_miso, 1'b0);
    tick(HALF);
    spi_ss = 1'b1;
    tick(2 * HALF);
    chk1("midrst_no_write", out_valid, 1'b0);
    chk1("midrst_txrdy", txrdy, 1'b1);
    exp_out_q.push_back(16'h8840);
    spi_xfer(16'h8840, 16, 1'b0);
    chk16("post_rst_out_data", out_data, 16'h8840);
    drain();

    tick(4);
    chki("out_queue_left", exp_out_q.size(), 0);
    chki("read_queue_left", exp_rd_q.size(), 0);
    chki("overflow_pulses", ovf_seen, exp_ovf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
